// File: rtl/spi_cmd_arbiter_if.sv
// rtl/spi_cmd_arbiter_if.sv - start/done handshake bundle between the arbiter and the 48-bit SPI master
//
// Signals (directions as seen from the arbiter, modport master):
//    spi_start_o  out  1   one-cycle start pulse to the SPI master
//    spi_cmd_o    out  48  frame to transmit, stable from start until done
//    spi_cs_o     out  1   card chip select, active-low
//    spi_done_i   in   1   one-cycle pulse, frame complete and spi_data_i valid
//    spi_data_i   in   48  received frame, response byte in [47:40]
// The slave modport is the SPI master's view of the same wires.

interface spi_cmd_arbiter_if;
   logic        spi_start_o;
   logic [47:0] spi_cmd_o;
   logic        spi_cs_o;
   logic        spi_done_i;
   logic [47:0] spi_data_i;

   modport master (
      output spi_start_o,
      output spi_cmd_o,
      output spi_cs_o,
      input  spi_done_i,
      input  spi_data_i
   );

   modport slave (
      input  spi_start_o,
      input  spi_cmd_o,
      input  spi_cs_o,
      output spi_done_i,
      output spi_data_i
   );
endinterface

// File: rtl/spi_cmd_arbiter.sv
// rtl/spi_cmd_arbiter.sv - two-requester command arbiter in front of a 48-bit-frame SPI master
//
// Grants one of two command requesters, sends its 48-bit command frame with chip
// select held low, polls with fill frames until the card returns an R1 byte other
// than NORESP_BYTE (or POLL_MAX fill frames have gone out), then acks the owner.
//
// Ports:
//    arb_clk_i   in   1   clock, rising edge
//    arb_rst_i   in   1   synchronous active-low reset
//    rN_req_i    in   1   requester N command request, level, held until rN_ack_o
//    rN_cmd_i    in   48  requester N command frame
//    rN_ack_o    out  1   one-cycle completion pulse to requester N
//    rN_err_o    out  1   valid with rN_ack_o, 1 = poll timeout
//    rN_resp_o   out  48  last received frame for requester N, held until next ack
//    spi         if       master modport of spi_cmd_arbiter_if (start/cmd/cs/done/data)
//    busy_o      out  1   high whenever the FSM is not IDLE
//    grant_o     out  2   one-hot current owner, 2'b00 when idle
//
// Build option ARB_FIXED_PRIO_EN: when defined, requester 0 always wins simultaneous
// requests and no round-robin pointer exists; otherwise round-robin arbitration.

module spi_cmd_arbiter #(
   parameter int unsigned  POLL_MAX    = 8,
   parameter logic [47:0]  FILL_CMD    = 48'hFFFF_FFFF_FFFF,
   parameter logic [7:0]   NORESP_BYTE = 8'hFF
) (
   input  logic           arb_clk_i,
   input  logic           arb_rst_i,

   input  logic           r0_req_i,
   input  logic [47:0]    r0_cmd_i,
   output logic           r0_ack_o,
   output logic           r0_err_o,
   output logic [47:0]    r0_resp_o,

   input  logic           r1_req_i,
   input  logic [47:0]    r1_cmd_i,
   output logic           r1_ack_o,
   output logic           r1_err_o,
   output logic [47:0]    r1_resp_o,

   spi_cmd_arbiter_if.master spi,

   output logic           busy_o,
   output logic [1:0]     grant_o
);

   localparam logic [7:0] POLL_MAX_C = 8'(POLL_MAX);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      WAIT  = 3'd2,
      CHECK = 3'd3,
      POLL  = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic        spi_start_q, spi_start_d;
   logic [47:0] spi_cmd_q, spi_cmd_d;
   logic        spi_cs_q, spi_cs_d;
   logic [1:0]  grant_q, grant_d;
   logic        busy_q, busy_d;
   logic [7:0]  poll_cnt_q, poll_cnt_d;
   logic [47:0] rx_data_q, rx_data_d;

   logic        r0_ack_q, r0_ack_d;
   logic        r0_err_q, r0_err_d;
   logic [47:0] r0_resp_q, r0_resp_d;
   logic        r1_ack_q, r1_ack_d;
   logic        r1_err_q, r1_err_d;
   logic [47:0] r1_resp_q, r1_resp_d;

`ifndef ARB_FIXED_PRIO_EN
   // 1 = requester 1 was granted last, 0 = requester 0 was granted last.
   logic        rr_last_q, rr_last_d;
`endif

   // A requester still holding req during its own ack cycle must not be regranted.
   logic        req0_v, req1_v;
   logic        pick0;
   logic        timeout_err;

   assign req0_v = r0_req_i & ~r0_ack_q;
   assign req1_v = r1_req_i & ~r1_ack_q;

   always_comb begin
      pick0 = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
      pick0 = req0_v;
`else
      // Requester 0 wins alone, or on a tie when requester 1 was served last.
      pick0 = req0_v & (~req1_v | rr_last_q);
`endif
   end

   assign timeout_err = (rx_data_q[47:40] == NORESP_BYTE);

   always_comb begin
      state_d     = state_q;
      spi_start_d = 1'b0;
      spi_cmd_d   = spi_cmd_q;
      spi_cs_d    = spi_cs_q;
      grant_d     = grant_q;
      poll_cnt_d  = poll_cnt_q;
      rx_data_d   = rx_data_q;
      r0_ack_d    = 1'b0;
      r0_err_d    = 1'b0;
      r0_resp_d   = r0_resp_q;
      r1_ack_d    = 1'b0;
      r1_err_d    = 1'b0;
      r1_resp_d   = r1_resp_q;
`ifndef ARB_FIXED_PRIO_EN
      rr_last_d   = rr_last_q;
`endif

      case (state_q)
         IDLE: begin
            if (req0_v || req1_v) begin
               state_d   = START;
               spi_cs_d  = 1'b0;
               grant_d   = pick0 ? 2'b01 : 2'b10;
               spi_cmd_d = pick0 ? r0_cmd_i : r1_cmd_i;
`ifndef ARB_FIXED_PRIO_EN
               rr_last_d = ~pick0;
`endif
            end
         end

         START: begin
            spi_start_d = 1'b1;
            state_d     = WAIT;
         end

         WAIT: begin
            if (spi.spi_done_i) begin
               rx_data_d = spi.spi_data_i;
               state_d   = CHECK;
            end
         end

         CHECK: begin
            if (rx_data_q[47:40] != NORESP_BYTE) begin
               state_d = DONE;
            end else if (poll_cnt_q < POLL_MAX_C) begin
               poll_cnt_d = poll_cnt_q + 8'd1;
               spi_cmd_d  = FILL_CMD;
               state_d    = POLL;
            end else begin
               state_d = DONE;
            end
         end

         POLL: begin
            spi_start_d = 1'b1;
            state_d     = WAIT;
         end

         DONE: begin
            // CHECK only reaches DONE with a no-response byte after the poll budget is spent.
            if (grant_q[0]) begin
               r0_ack_d  = 1'b1;
               r0_err_d  = timeout_err;
               r0_resp_d = rx_data_q;
            end else if (grant_q[1]) begin
               r1_ack_d  = 1'b1;
               r1_err_d  = timeout_err;
               r1_resp_d = rx_data_q;
            end
            spi_cs_d   = 1'b1;
            grant_d    = 2'b00;
            poll_cnt_d = 8'd0;
            state_d    = IDLE;
         end

         default: begin
            state_d  = IDLE;
            spi_cs_d = 1'b1;
            grant_d  = 2'b00;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge arb_clk_i) begin
      if (!arb_rst_i) begin
         state_q     <= IDLE;
         spi_start_q <= 1'b0;
         spi_cmd_q   <= FILL_CMD;
         spi_cs_q    <= 1'b1;
         grant_q     <= 2'b00;
         busy_q      <= 1'b0;
         poll_cnt_q  <= 8'd0;
         rx_data_q   <= 48'd0;
         r0_ack_q    <= 1'b0;
         r0_err_q    <= 1'b0;
         r0_resp_q   <= 48'd0;
         r1_ack_q    <= 1'b0;
         r1_err_q    <= 1'b0;
         r1_resp_q   <= 48'd0;
`ifndef ARB_FIXED_PRIO_EN
         rr_last_q   <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         spi_start_q <= spi_start_d;
         spi_cmd_q   <= spi_cmd_d;
         spi_cs_q    <= spi_cs_d;
         grant_q     <= grant_d;
         busy_q      <= busy_d;
         poll_cnt_q  <= poll_cnt_d;
         rx_data_q   <= rx_data_d;
         r0_ack_q    <= r0_ack_d;
         r0_err_q    <= r0_err_d;
         r0_resp_q   <= r0_resp_d;
         r1_ack_q    <= r1_ack_d;
         r1_err_q    <= r1_err_d;
         r1_resp_q   <= r1_resp_d;
`ifndef ARB_FIXED_PRIO_EN
         rr_last_q   <= rr_last_d;
`endif
      end
   end

   assign spi.spi_start_o = spi_start_q;
   assign spi.spi_cmd_o   = spi_cmd_q;
   assign spi.spi_cs_o    = spi_cs_q;

   assign r0_ack_o  = r0_ack_q;
   assign r0_err_o  = r0_err_q;
   assign r0_resp_o = r0_resp_q;
   assign r1_ack_o  = r1_ack_q;
   assign r1_err_o  = r1_err_q;
   assign r1_resp_o = r1_resp_q;
   assign busy_o    = busy_q;
   assign grant_o   = grant_q;

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// tb/tb_spi_cmd_arbiter.sv - scoreboard bench for spi_cmd_arbiter

module tb_spi_cmd_arbiter;

   localparam logic [47:0] FILL = 48'hFFFF_FFFF_FFFF;

   typedef struct packed {
      logic        id;
      logic        err;
      logic [47:0] resp;
   } ack_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        r0_req = 1'b0;
   logic        r1_req = 1'b0;
   logic [47:0] r0_cmd = 48'd0;
   logic [47:0] r1_cmd = 48'd0;
   logic        r0_ack, r0_err, r1_ack, r1_err, busy;
   logic [47:0] r0_resp, r1_resp;
   logic [1:0]  grant;

   logic        mdl_done = 1'b0;
   logic        man_done = 1'b0;
   logic [47:0] mdl_data = 48'd0;
   logic [47:0] man_data = 48'd0;
   logic        model_en = 1'b1;

   spi_cmd_arbiter_if spi_if();

   assign spi_if.spi_done_i = mdl_done | man_done;
   assign spi_if.spi_data_i = man_done ? man_data : mdl_data;

   spi_cmd_arbiter dut (
      .arb_clk_i (clk),
      .arb_rst_i (rstn),
      .r0_req_i  (r0_req),
      .r0_cmd_i  (r0_cmd),
      .r0_ack_o  (r0_ack),
      .r0_err_o  (r0_err),
      .r0_resp_o (r0_resp),
      .r1_req_i  (r1_req),
      .r1_cmd_i  (r1_cmd),
      .r1_ack_o  (r1_ack),
      .r1_err_o  (r1_err),
      .r1_resp_o (r1_resp),
      .spi       (spi_if),
      .busy_o    (busy),
      .grant_o   (grant)
   );

   always #5 clk = ~clk;

   ack_t        exp_ack_q[$];
   logic [47:0] exp_tx_q[$];
   logic [1:0]  exp_grant_q[$];
   logic [47:0] rsp_q[$];

   int cmp_cnt = 0;
   int err_cnt = 0;
   int start_cnt = 0;

   function automatic void chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endfunction

   function automatic void bad(input string name, input logic [47:0] act);
      cmp_cnt++;
      err_cnt++;
      $display("FAIL %s: actual %h required nothing", name, act);
   endfunction

   function automatic ack_t mk_ack(input logic id, input logic err, input logic [47:0] resp);
      ack_t a;
      a.id   = id;
      a.err  = err;
      a.resp = resp;
      return a;
   endfunction

   // Monitor: pops expectations whenever the DUT presents an ack, start or new grant.
   initial begin : monitor
      ack_t        e;
      logic        prev_cs;
      logic [1:0]  prev_grant;
      prev_cs    = 1'b1;
      prev_grant = 2'b00;
      forever begin
         @(negedge clk);
         if (r0_ack || r1_ack) begin
            if (exp_ack_q.size() == 0) begin
               bad("ack_unexpected", {46'd0, r1_ack, r0_ack});
            end else begin
               e = exp_ack_q.pop_front();
               chk("ack_owner", {47'd0, r1_ack}, {47'd0, e.id});
               chk("ack_single", {47'd0, r0_ack & r1_ack}, 48'd0);
               chk("ack_err", {47'd0, e.id ? r1_err : r0_err}, {47'd0, e.err});
               chk("ack_resp", e.id ? r1_resp : r0_resp, e.resp);
               chk("ack_cs_high", {47'd0, spi_if.spi_cs_o}, 48'd1);
               chk("ack_grant_idle", {46'd0, grant}, 48'd0);
            end
         end
         if (spi_if.spi_start_o) begin
            start_cnt++;
            if (exp_tx_q.size() == 0) begin
               bad("start_unexpected", spi_if.spi_cmd_o);
            end else begin
               chk("tx_frame", spi_if.spi_cmd_o, exp_tx_q.pop_front());
               chk("tx_cs_low", {47'd0, spi_if.spi_cs_o}, 48'd0);
            end
         end
         if (grant != 2'b00 && prev_grant == 2'b00) begin
            if (exp_grant_q.size() == 0) begin
               bad("grant_unexpected", {46'd0, grant});
            end else begin
               chk("grant_owner", {46'd0, grant}, {46'd0, exp_grant_q.pop_front()});
               chk("grant_gap_cs", {47'd0, prev_cs}, 48'd1);
               chk("grant_cs_low", {47'd0, spi_if.spi_cs_o}, 48'd0);
            end
         end
         prev_cs    = spi_if.spi_cs_o;
         prev_grant = grant;
      end
   end

   // SPI master model: answers each start with the next queued frame a few cycles later.
   initial begin : spi_model
      forever begin
         @(negedge clk);
         if (spi_if.spi_start_o && model_en) begin
            repeat (2) @(posedge clk);
            #1;
            mdl_data = (rsp_q.size() != 0) ? rsp_q.pop_front() : FILL;
            mdl_done = 1'b1;
            @(posedge clk);
            #1;
            mdl_done = 1'b0;
         end
      end
   end

   // Called at a negedge; returns at the negedge where the ack is visible.
   task automatic wait_ack(input int id);
      for (int n = 0; n < 600; n++) begin
         if ((id == 0) ? r0_ack : r1_ack) return;
         @(negedge clk);
      end
      bad("ack_timeout", 48'(id));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_start"}, {47'd0, spi_if.spi_start_o}, 48'd0);
      chk({tag, "_cmd"}, spi_if.spi_cmd_o, FILL);
      chk({tag, "_cs"}, {47'd0, spi_if.spi_cs_o}, 48'd1);
      chk({tag, "_busy"}, {47'd0, busy}, 48'd0);
      chk({tag, "_grant"}, {46'd0, grant}, 48'd0);
      chk({tag, "_acks"}, {46'd0, r1_ack, r0_ack}, 48'd0);
      chk({tag, "_errs"}, {46'd0, r1_err, r0_err}, 48'd0);
      chk({tag, "_r0_resp"}, r0_resp, 48'd0);
      chk({tag, "_r1_resp"}, r1_resp, 48'd0);
   endtask

   logic [47:0] rr_cmd0 [2];
   logic [47:0] rr_cmd1 [2];
   logic [47:0] rr_rsp0 [2];
   logic [47:0] rr_rsp1 [2];

   initial begin : stimulus
      int snap;
      int found;

      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      check_reset_outputs("rst");

      // Single r0 command answered on the first frame; start appears two cycles after req.
      exp_grant_q.push_back(2'b01);
      exp_tx_q.push_back(48'h4000_0000_0095);
      rsp_q.push_back(48'h0111_2233_4455);
      exp_ack_q.push_back(mk_ack(1'b0, 1'b0, 48'h0111_2233_4455));
      snap = start_cnt;
      @(posedge clk);
      #1;
      r0_cmd = 48'h4000_0000_0095;
      r0_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("lat_cycle1_start", {47'd0, spi_if.spi_start_o}, 48'd0);
      chk("lat_cycle1_busy", {47'd0, busy}, 48'd1);
      @(negedge clk);
      chk("lat_cycle2_start", {47'd0, spi_if.spi_start_o}, 48'd1);
      wait_ack(0);
      r0_req = 1'b0;
      chk("t1_starts", 48'(start_cnt - snap), 48'd1);
      chk("t1_r1_resp_untouched", r1_resp, 48'd0);

      // r1 command, two no-response frames then R1 = 00.
      exp_grant_q.push_back(2'b10);
      exp_tx_q.push_back(48'h5100_0008_00FF);
      exp_tx_q.push_back(FILL);
      exp_tx_q.push_back(FILL);
      rsp_q.push_back(48'hFFFF_FFFF_FFFF);
      rsp_q.push_back(48'hFF00_0000_0001);
      rsp_q.push_back(48'h00AB_CDEF_0123);
      exp_ack_q.push_back(mk_ack(1'b1, 1'b0, 48'h00AB_CDEF_0123));
      snap = start_cnt;
      @(posedge clk);
      #1;
      r1_cmd = 48'h5100_0008_00FF;
      r1_req = 1'b1;
      @(negedge clk);
      wait_ack(1);
      r1_req = 1'b0;
      chk("t2_starts", 48'(start_cnt - snap), 48'd3);
      chk("t2_r0_resp_untouched", r0_resp, 48'h0111_2233_4455);

      // Simultaneous requests, twice: r1 was served last, so r0, r1, r0, r1.
      rr_cmd0[0] = 48'h4A00_0000_0011;  rr_cmd1[0] = 48'h5100_0002_00AA;
      rr_cmd0[1] = 48'h4B00_0000_0022;  rr_cmd1[1] = 48'h5200_0003_00BB;
      rr_rsp0[0] = 48'h0010_0000_0001;  rr_rsp1[0] = 48'h0020_0000_0002;
      rr_rsp0[1] = 48'h0130_0000_0003;  rr_rsp1[1] = 48'h0040_0000_0004;
      for (int k = 0; k < 2; k++) begin
         exp_grant_q.push_back(2'b01);
         exp_grant_q.push_back(2'b10);
         exp_tx_q.push_back(rr_cmd0[k]);
         exp_tx_q.push_back(rr_cmd1[k]);
         rsp_q.push_back(rr_rsp0[k]);
         rsp_q.push_back(rr_rsp1[k]);
         exp_ack_q.push_back(mk_ack(1'b0, 1'b0, rr_rsp0[k]));
         exp_ack_q.push_back(mk_ack(1'b1, 1'b0, rr_rsp1[k]));
         @(posedge clk);
         #1;
         r0_cmd = rr_cmd0[k];
         r1_cmd = rr_cmd1[k];
         r0_req = 1'b1;
         r1_req = 1'b1;
         @(negedge clk);
         wait_ack(0);
         r0_req = 1'b0;
         wait_ack(1);
         r1_req = 1'b0;
      end

      // Poll timeout: every frame returns FF, POLL_MAX = 8 gives 9 frames and err.
      exp_grant_q.push_back(2'b01);
      exp_tx_q.push_back(48'h4C00_0000_0001);
      for (int i = 0; i < 8; i++) exp_tx_q.push_back(FILL);
      for (int i = 0; i < 9; i++) rsp_q.push_back(48'hFF00_0000_0000 | 48'(i));
      exp_ack_q.push_back(mk_ack(1'b0, 1'b1, 48'hFF00_0000_0008));
      snap = start_cnt;
      @(posedge clk);
      #1;
      r0_cmd = 48'h4C00_0000_0001;
      r0_req = 1'b1;
      @(negedge clk);
      wait_ack(0);
      r0_req = 1'b0;
      chk("t3_starts", 48'(start_cnt - snap), 48'd9);

      // Reset while waiting for done, then a stray done: no ack, everything at reset values.
      model_en = 1'b0;
      exp_grant_q.push_back(2'b10);
      exp_tx_q.push_back(48'h5100_0004_00CC);
      @(posedge clk);
      #1;
      r1_cmd = 48'h5100_0004_00CC;
      r1_req = 1'b1;
      found = 0;
      for (int n = 0; n < 20 && found == 0; n++) begin
         @(negedge clk);
         if (spi_if.spi_start_o) found = 1;
      end
      if (found == 0) bad("t5_start_timeout", 48'd0);
      @(posedge clk);
      #1;
      rstn   = 1'b0;
      r1_req = 1'b0;
      @(posedge clk);
      #1;
      rstn     = 1'b1;
      man_data = 48'h00DE_ADBE_EF00;
      man_done = 1'b1;
      @(posedge clk);
      #1;
      man_done = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("abort");

      // Done while idle is ignored; cmd change after grant does not reach the wire.
      @(posedge clk);
      #1;
      man_data = 48'h01AA_AAAA_AAAA;
      man_done = 1'b1;
      @(posedge clk);
      #1;
      man_done = 1'b0;
      @(negedge clk);
      chk("idle_done_busy", {47'd0, busy}, 48'd0);
      chk("idle_done_grant", {46'd0, grant}, 48'd0);
      model_en = 1'b1;
      exp_grant_q.push_back(2'b01);
      exp_tx_q.push_back(48'h7700_0000_00AB);
      rsp_q.push_back(48'h0000_0000_C3C3);
      exp_ack_q.push_back(mk_ack(1'b0, 1'b0, 48'h0000_0000_C3C3));
      @(posedge clk);
      #1;
      r0_cmd = 48'h7700_0000_00AB;
      r0_req = 1'b1;
      found = 0;
      for (int n = 0; n < 20 && found == 0; n++) begin
         @(negedge clk);
         if (grant != 2'b00) found = 1;
      end
      if (found == 0) bad("t6_grant_timeout", 48'd0);
      r0_cmd = 48'h1234_5678_9ABC;
      wait_ack(0);
      r0_req = 1'b0;
      chk("t6_r1_resp_untouched", r1_resp, 48'd0);

      repeat (5) @(negedge clk);
      chk("left_acks", 48'(exp_ack_q.size()), 48'd0);
      chk("left_frames", 48'(exp_tx_q.size()), 48'd0);
      chk("left_grants", 48'(exp_grant_q.size()), 48'd0);
      chk("left_responses", 48'(rsp_q.size()), 48'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL global_timeout: actual running required finished");
      $fatal(1, "watchdog expired");
   end

endmodule
